mem_stage: RTL and testbench

Memory-access stage of the multistage MIPS pipeline. Consumes the 107-bit EX/MEM bundle, resolves branch/jump redirection, and performs loads/stores against an internal data memory whose access takes a configurable number of wait cycles. Stalls the upstream pipeline during multi-cycle accesses. Registers the result into the 71-bit MEM/WB bundle for write-back.

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/data_memory.sv | 23 ++
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared field layout of the EX/MEM and MEM/WB pipeline bundles, and the
// state type of the memory-stage access FSM.
package pipeline_pkg;

  localparam int EX_MEM_W      = 107;
  localparam int EXM_BRANCH    = 106;
  localparam int EXM_MEMTOREG  = 105;
  localparam int EXM_MEMWRITE  = 104;
  localparam int EXM_REGWRITE  = 103;
  localparam int EXM_JUMP      = 102;
  localparam int EXM_BADD_HI   = 101;
  localparam int EXM_BADD_LO   = 70;
  localparam int EXM_ZERO      = 69;
  localparam int EXM_ALU_HI    = 68;
  localparam int EXM_ALU_LO    = 37;
  localparam int EXM_SDATA_HI  = 36;
  localparam int EXM_SDATA_LO  = 5;
  localparam int EXM_WREG_HI   = 4;
  localparam int EXM_WREG_LO   = 0;

  localparam int MEM_WB_W      = 71;
  localparam int MWB_REGWRITE  = 70;
  localparam int MWB_MEMTOREG  = 69;
  localparam int MWB_RDATA_HI  = 68;
  localparam int MWB_RDATA_LO  = 37;
  localparam int MWB_ALU_HI    = 36;
  localparam int MWB_ALU_LO    = 5;
  localparam int MWB_WREG_HI   = 4;
  localparam int MWB_WREG_LO   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous write, asynchronous read, no reset so
// contents survive a pipeline reset.
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port, committed on the rising edge.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: branch/jump redirect, multi-cycle data memory
// access with upstream stall, and the MEM/WB pipeline register.
//
//   state | meaning
//   IDLE  | new instruction evaluated; non-memory ops complete here
//   WAIT  | memory access in flight; cnt counts remaining wait cycles
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [EX_MEM_W-1:0] ex_mem_in,
  input  logic                ex_mem_valid,
  output logic                stall,
  output logic                pc_src,
  output logic [31:0]         branch_target,
  output logic [MEM_WB_W-1:0] mem_wb_out,
  output logic                mem_wb_valid,
  output logic                addr_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  logic          branch;
  logic          mem_to_reg;
  logic          mem_write;
  logic          reg_write;
  logic          jump;
  logic          zero;
  logic [31:0]   alu_out;
  logic [31:0]   store_data;
  logic [4:0]    write_reg;
  logic [AW-1:0] word_addr;
  logic          misaligned;
  logic          mem_op;

  assign branch        = ex_mem_in[EXM_BRANCH];
  assign mem_to_reg    = ex_mem_in[EXM_MEMTOREG];
  assign mem_write     = ex_mem_in[EXM_MEMWRITE];
  assign reg_write     = ex_mem_in[EXM_REGWRITE];
  assign jump          = ex_mem_in[EXM_JUMP];
  assign zero          = ex_mem_in[EXM_ZERO];
  assign alu_out       = ex_mem_in[EXM_ALU_HI:EXM_ALU_LO];
  assign store_data    = ex_mem_in[EXM_SDATA_HI:EXM_SDATA_LO];
  assign write_reg     = ex_mem_in[EXM_WREG_HI:EXM_WREG_LO];
  assign branch_target = ex_mem_in[EXM_BADD_HI:EXM_BADD_LO];

  // Upper address bits are dropped on purpose: accesses wrap modulo DEPTH.
  assign word_addr  = alu_out[AW+1:2];
  assign misaligned = |alu_out[1:0];
  assign mem_op     = ex_mem_valid & (mem_write | mem_to_reg);

  // Redirect is independent of stall; branches never occupy the memory FSM.
  assign pc_src = ex_mem_valid & ((branch & zero) | jump);

  mem_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       complete;

  // Next-state, wait-counter and stall/complete decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && HAS_WAIT) begin
          state_nx = WAIT;
          cnt_nx   = CNT_LOAD;
          stall    = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
          stall  = 1'b1;
        end else begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // FSM state and wait down-counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] read_data;

  // Reset on the completion edge must also suppress the write.
  assign mem_we    = reset_n & complete & ex_mem_valid & mem_write & ~misaligned;
  assign read_data = (ex_mem_valid & mem_to_reg & ~misaligned) ? mem_rdata : 32'd0;

  data_memory #(.DEPTH(DEPTH)) u_dmem (
    .clock (clock),
    .we    (mem_we),
    .addr  (word_addr),
    .wdata (store_data),
    .rdata (mem_rdata)
  );

  // MEM/WB register: real instruction on completion, bubble otherwise.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_wb_out   <= '0;
      mem_wb_valid <= 1'b0;
    end else if (complete && ex_mem_valid) begin
      mem_wb_out   <= {reg_write, mem_to_reg, read_data, alu_out, write_reg};
      mem_wb_valid <= 1'b1;
    end else begin
      mem_wb_out   <= '0;
      mem_wb_valid <= 1'b0;
    end
  end

  // Sticky misaligned-access flag, raised when the offending op retires.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if (complete && mem_op && misaligned) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with MEM_LATENCY=2 (index 0)
// and one with MEM_LATENCY=0 (index 1), checked every cycle against a
// transaction-level model of the stage.
module tb_mem_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n;
  logic [106:0] in_a   [2];
  logic         vin    [2];
  logic         stall_o[2];
  logic         pc_o   [2];
  logic [31:0]  tgt_o  [2];
  logic [70:0]  mwb_o  [2];
  logic         mv_o   [2];
  logic         aerr_o [2];

  mem_stage #(.DEPTH(256), .MEM_LATENCY(2)) dut_l2 (
    .clock(clock), .reset_n(reset_n), .ex_mem_in(in_a[0]), .ex_mem_valid(vin[0]),
    .stall(stall_o[0]), .pc_src(pc_o[0]), .branch_target(tgt_o[0]),
    .mem_wb_out(mwb_o[0]), .mem_wb_valid(mv_o[0]), .addr_err(aerr_o[0]));

  mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) dut_l0 (
    .clock(clock), .reset_n(reset_n), .ex_mem_in(in_a[1]), .ex_mem_valid(vin[1]),
    .stall(stall_o[1]), .pc_src(pc_o[1]), .branch_target(tgt_o[1]),
    .mem_wb_out(mwb_o[1]), .mem_wb_valid(mv_o[1]), .addr_err(aerr_o[1]));

  // model state
  logic         e_stall[2];
  logic         e_pc   [2];
  logic [31:0]  e_tgt  [2];
  logic [70:0]  e_mwb  [2];
  logic         e_mv   [2];
  logic         e_aerr [2];
  logic [31:0]  mm     [2][256];

  int  tests;
  int  fails;
  int  stall_cnt[2];
  int  pc_cnt[2];
  bit  chk_en;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [106:0] mk(input logic br, input logic m2r, input logic mw,
                                      input logic rw, input logic jmp, input logic [31:0] tgt,
                                      input logic z, input logic [31:0] alu,
                                      input logic [31:0] sd, input logic [4:0] wr);
    return {br, m2r, mw, rw, jmp, tgt, z, alu, sd, wr};
  endfunction

  // Retirement rules of one instruction applied to model d.
  task automatic retire(input int d, input logic v, input logic [106:0] b);
    logic [31:0] alu;
    logic [31:0] rd;
    logic        mis;
    int          w;
    alu = b[68:37];
    mis = (alu[1:0] != 2'b00);
    w   = int'(alu[9:2]);
    rd  = 32'd0;
    if (v && b[105] && !mis) rd = mm[d][w];
    if (v && b[104] && !mis) mm[d][w] = b[36:5];
    if (v && (b[104] || b[105]) && mis) e_aerr[d] = 1'b1;
    e_mwb[d] = v ? {b[103], b[105], rd, alu, b[4:0]} : 71'd0;
    e_mv[d]  = v;
  endtask

  // Present one instruction to DUT d (other DUT sees bubbles) for its full occupancy.
  task automatic issue(input int d, input logic v, input logic [106:0] b);
    int o;
    int n;
    int lat;
    o   = 1 - d;
    lat = (d == 0) ? 2 : 0;
    n   = (v && (b[104] || b[105])) ? lat + 1 : 1;
    for (int k = 0; k < n; k++) begin
      in_a[d] = b;        vin[d] = v;
      in_a[o] = '0;       vin[o] = 1'b0;
      e_stall[d] = (k < n - 1);
      e_pc[d]    = v & ((b[106] & b[69]) | b[102]);
      e_tgt[d]   = b[101:70];
      e_stall[o] = 1'b0;  e_pc[o] = 1'b0;  e_tgt[o] = 32'd0;
      @(posedge clock); #1;
      e_mwb[o] = '0;  e_mv[o] = 1'b0;
      if (k < n - 1) begin
        e_mwb[d] = '0;  e_mv[d] = 1'b0;
      end else begin
        retire(d, v, b);
      end
    end
  endtask

  int s0;
  int p0;

  initial begin
    tests = 0; fails = 0; chk_en = 0;
    for (int d = 0; d < 2; d++) begin
      in_a[d] = '0; vin[d] = 1'b0;
      e_stall[d] = 0; e_pc[d] = 0; e_tgt[d] = 0; e_mwb[d] = 0; e_mv[d] = 0; e_aerr[d] = 0;
      stall_cnt[d] = 0; pc_cnt[d] = 0;
    end

    fork
      forever begin
        @(negedge clock);
        if (chk_en) begin
          for (int d = 0; d < 2; d++) begin
            check($sformatf("stall[%0d]", d), 71'(stall_o[d]), 71'(e_stall[d]));
            check($sformatf("pc_src[%0d]", d), 71'(pc_o[d]), 71'(e_pc[d]));
            check($sformatf("branch_target[%0d]", d), 71'(tgt_o[d]), 71'(e_tgt[d]));
            check($sformatf("mem_wb_out[%0d]", d), mwb_o[d], e_mwb[d]);
            check($sformatf("mem_wb_valid[%0d]", d), 71'(mv_o[d]), 71'(e_mv[d]));
            check($sformatf("addr_err[%0d]", d), 71'(aerr_o[d]), 71'(e_aerr[d]));
            if (stall_o[d] === 1'b1) stall_cnt[d]++;
            if (pc_o[d] === 1'b1) pc_cnt[d]++;
          end
        end
      end
    join_none

    reset_n = 1'b0;
    @(posedge clock); #1;
    chk_en = 1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("reset mem_wb_out", mwb_o[0], 71'd0);
    check("reset addr_err", 71'(aerr_o[0]), 71'd0);

    // store 0xDEADBEEF to 0x10, then load it back
    s0 = stall_cnt[0];
    issue(0, 1, mk(0,0,1,0,0, 32'd0, 0, 32'h10, 32'hDEADBEEF, 5'd0));
    check("store stall cycles", 71'(stall_cnt[0] - s0), 71'd2);
    s0 = stall_cnt[0];
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h10, 32'd0, 5'd5));
    check("load stall cycles", 71'(stall_cnt[0] - s0), 71'd2);
    check("load 0x10 data", 71'(mwb_o[0][68:37]), 71'h0DEADBEEF);
    check("load 0x10 valid", 71'(mv_o[0]), 71'd1);

    // branches and jump
    p0 = pc_cnt[0];
    issue(0, 1, mk(1,0,0,0,0, 32'h0040_0020, 1, 32'd0, 32'd0, 5'd0));
    check("taken branch pc_src cycles", 71'(pc_cnt[0] - p0), 71'd1);
    p0 = pc_cnt[0];
    issue(0, 1, mk(1,0,0,0,0, 32'h0040_0020, 0, 32'd0, 32'd0, 5'd0));
    check("untaken branch pc_src cycles", 71'(pc_cnt[0] - p0), 71'd0);
    issue(0, 1, mk(0,0,0,0,1, 32'h0000_1234, 0, 32'd0, 32'd0, 5'd0));
    issue(0, 0, mk(1,0,0,0,1, 32'h0000_5678, 1, 32'd0, 32'd0, 5'd0));

    // wrap: 0x404 aliases word 1
    issue(0, 1, mk(0,0,1,0,0, 32'd0, 0, 32'h404, 32'h12345678, 5'd0));
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h004, 32'd0, 5'd7));
    check("wrap load data", 71'(mwb_o[0][68:37]), 71'h12345678);

    // misaligned load, sticky flag
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h006, 32'd0, 5'd8));
    check("misaligned read_data", 71'(mwb_o[0][68:37]), 71'd0);
    check("addr_err set", 71'(aerr_o[0]), 71'd1);

    // ALU op then back-to-back load
    issue(0, 1, mk(0,0,0,1,0, 32'd0, 0, 32'd7, 32'd0, 5'd3));
    check("alu mem_wb", mwb_o[0], {1'b1, 1'b0, 32'd0, 32'd7, 5'd3});
    check("addr_err sticky", 71'(aerr_o[0]), 71'd1);
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h10, 32'd0, 5'd9));

    // store+load on same op returns pre-write word
    issue(0, 1, mk(0,0,1,0,0, 32'd0, 0, 32'h8, 32'h11, 5'd0));
    issue(0, 1, mk(0,1,1,1,0, 32'd0, 0, 32'h8, 32'h22, 5'd4));
    check("rmw old data", 71'(mwb_o[0][68:37]), 71'h11);
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h8, 32'd0, 5'd4));
    check("rmw new data", 71'(mwb_o[0][68:37]), 71'h22);

    // bubble carrying a store must not write
    issue(0, 0, mk(0,0,1,0,0, 32'd0, 0, 32'h10, 32'h0BAD0BAD, 5'd0));
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h10, 32'd0, 5'd1));
    check("bubble no write", 71'(mwb_o[0][68:37]), 71'h0DEADBEEF);

    // zero-latency instance
    issue(1, 1, mk(0,0,1,0,0, 32'd0, 0, 32'h40, 32'hCAFEF00D, 5'd0));
    issue(1, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h40, 32'd0, 5'd2));
    check("lat0 load data", 71'(mwb_o[1][68:37]), 71'h0CAFEF00D);
    check("lat0 never stalls", 71'(stall_cnt[1]), 71'd0);

    // reset during WAIT of a store to 0x20
    issue(0, 1, mk(0,0,1,0,0, 32'd0, 0, 32'h20, 32'h88880000, 5'd0));
    in_a[0] = mk(0,0,1,0,0, 32'd0, 0, 32'h20, 32'h00000BAD, 5'd0);
    vin[0] = 1'b1;  in_a[1] = '0;  vin[1] = 1'b0;
    e_stall[0] = 1'b1;  e_pc[0] = 1'b0;  e_tgt[0] = 32'd0;
    e_stall[1] = 1'b0;  e_pc[1] = 1'b0;  e_tgt[1] = 32'd0;
    @(posedge clock); #1;
    e_mwb[0] = '0; e_mv[0] = 0; e_mwb[1] = '0; e_mv[1] = 0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      e_mwb[d] = '0; e_mv[d] = 0; e_aerr[d] = 0;
    end
    vin[0] = 1'b0;  in_a[0] = '0;
    e_stall[0] = 1'b0;
    check("post-reset mem_wb", mwb_o[0], 71'd0);
    check("post-reset addr_err", 71'(aerr_o[0]), 71'd0);
    issue(0, 1, mk(0,1,0,1,0, 32'd0, 0, 32'h20, 32'd0, 5'd6));
    check("aborted store left word 8", 71'(mwb_o[0][68:37]), 71'h088880000);

    issue(0, 0, '0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
